// File: rtl/ram_burst_rd_pkg.sv
// Shared types, default widths and helpers for the RAM burst reader.
package ram_burst_rd_pkg;

    localparam int CAddrLen = 13;
    localparam int CDataLen = 128;
    localparam int CLenLen  = 16;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Run   = 2'd1,
        Drain = 2'd2
    } state_e;

    // Smallest pointer width that can index a FIFO of the given depth (at least 1).
    function automatic int f_ptr_w(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ram_burst_rd_if.sv
// Request, RAM-port and stream signals of the burst reader; AAbort exists only
// when RAM_BURST_RD_ABORT_EN is defined.
interface ram_burst_rd_if #(
    parameter int CAddrLen = ram_burst_rd_pkg::CAddrLen,
    parameter int CDataLen = ram_burst_rd_pkg::CDataLen,
    parameter int CLenLen  = ram_burst_rd_pkg::CLenLen
);
    logic                AReqStart;
    logic [CAddrLen-1:0] AReqAddr;
    logic [CLenLen-1:0]  AReqLen;
    logic                ABusy;
    logic                ADone;
    logic [CAddrLen-1:0] ARamAddr;
    logic                ARamRdEn;
    logic [CDataLen-1:0] ARamMiso;
    logic [CDataLen-1:0] AStrData;
    logic                AStrVld;
    logic                AStrLast;
    logic                AStrRdy;
`ifdef RAM_BURST_RD_ABORT_EN
    logic                AAbort;

    modport master (
        input  AReqStart, AReqAddr, AReqLen, ARamMiso, AStrRdy, AAbort,
        output ABusy, ADone, ARamAddr, ARamRdEn, AStrData, AStrVld, AStrLast
    );
    modport slave (
        output AReqStart, AReqAddr, AReqLen, ARamMiso, AStrRdy, AAbort,
        input  ABusy, ADone, ARamAddr, ARamRdEn, AStrData, AStrVld, AStrLast
    );
`else
    modport master (
        input  AReqStart, AReqAddr, AReqLen, ARamMiso, AStrRdy,
        output ABusy, ADone, ARamAddr, ARamRdEn, AStrData, AStrVld, AStrLast
    );
    modport slave (
        output AReqStart, AReqAddr, AReqLen, ARamMiso, AStrRdy,
        input  ABusy, ADone, ARamAddr, ARamRdEn, AStrData, AStrVld, AStrLast
    );
`endif
endinterface

// File: rtl/ram_burst_rd_fifo.sv
// Synchronous FIFO holding {last, data} beats; flush empties it in one enabled cycle.
module ram_burst_rd_fifo import ram_burst_rd_pkg::*; #(
    parameter int CDepth = 4,
    parameter int CWidth = 129,
    localparam int PtrW  = f_ptr_w(CDepth)
) (
    input  logic              AClkH,
    input  logic              AResetHN,
    input  logic              AClkHEn,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [CWidth-1:0] wr_data,
    input  logic              rd_en,
    output logic [CWidth-1:0] rd_data,
    output logic [PtrW:0]     count,
    output logic              empty,
    output logic              full
);
    logic [CWidth-1:0] mem_q [CDepth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic              do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PtrW+1)'(CDepth));
    assign count   = count_q;
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    // Idle output reads as zero so nothing stale leaks out after a flush.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
            else       wr_ptr_d = wr_ptr_q;
            if (do_rd) rd_ptr_d = rd_ptr_q + PtrW'(1);
            else       rd_ptr_d = rd_ptr_q;
            if (do_wr && !do_rd)      count_d = count_q + (PtrW+1)'(1);
            else if (do_rd && !do_wr) count_d = count_q - (PtrW+1)'(1);
            else                      count_d = count_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (AClkHEn) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array.
    always_ff @(posedge AClkH) begin
        if (AClkHEn && do_wr && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/ram_burst_rd.sv
// Burst read initiator: sequential RAM reads with credit flow control into a
// valid/ready stream. Optional abort input under RAM_BURST_RD_ABORT_EN.
module ram_burst_rd #(
    parameter int CAddrLen   = ram_burst_rd_pkg::CAddrLen,
    parameter int CDataLen   = ram_burst_rd_pkg::CDataLen,
    parameter int CLenLen    = ram_burst_rd_pkg::CLenLen,
    parameter int CFifoDepth = 4
) (
    input  logic           AClkH,
    input  logic           AResetHN,
    input  logic           AClkHEn,
    ram_burst_rd_if.master bus
);
    import ram_burst_rd_pkg::*;

    localparam int PtrW = f_ptr_w(CFifoDepth);

    state_e              state_q, state_d;
    logic [CAddrLen-1:0] addr_q, addr_d;
    logic [CAddrLen-1:0] ram_addr_q, ram_addr_d;
    logic [CLenLen-1:0]  remaining_q, remaining_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
    logic                done_q, done_d;

    logic                issue, pop, abort, credit_ok;
    logic                fifo_empty, fifo_full;
    logic [PtrW:0]       fifo_count;
    logic [CDataLen:0]   fifo_rd_data;

`ifdef RAM_BURST_RD_ABORT_EN
    assign abort = bus.AAbort & (state_q != Idle);
`else
    assign abort = 1'b0;
`endif

    // A FIFO slot is reserved for every read still travelling through the RAM.
    assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < CFifoDepth;
    assign issue     = (state_q == Run) & (remaining_q != '0) & AClkHEn
                     & credit_ok & ~fifo_full & ~abort;
    assign pop       = ~fifo_empty & bus.AStrRdy & AClkHEn;

    ram_burst_rd_fifo #(
        .CDepth (CFifoDepth),
        .CWidth (CDataLen + 1)
    ) u_fifo (
        .AClkH    (AClkH),
        .AResetHN (AResetHN),
        .AClkHEn  (AClkHEn),
        .flush    (abort),
        .wr_en    (inflight_q),
        .wr_data  ({inflight_last_q, bus.ARamMiso}),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Burst FSM next-state, address/length bookkeeping and done pulse.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        ram_addr_d      = ram_addr_q;
        remaining_d     = remaining_q;
        inflight_d      = issue;
        inflight_last_d = issue & (remaining_q == CLenLen'(1));
        done_d          = 1'b0;
        case (state_q)
            Idle: begin
                if (bus.AReqStart && (bus.AReqLen != '0)) begin
                    state_d     = Run;
                    addr_d      = bus.AReqAddr;
                    remaining_d = bus.AReqLen;
                end else if (bus.AReqStart) begin
                    done_d = 1'b1;
                end else begin
                    state_d = Idle;
                end
            end
            Run: begin
                if (issue) begin
                    ram_addr_d  = addr_q;
                    addr_d      = addr_q + CAddrLen'(1);
                    remaining_d = remaining_q - CLenLen'(1);
                    if (remaining_q == CLenLen'(1)) state_d = Drain;
                    else                            state_d = Run;
                end else begin
                    state_d = Run;
                end
            end
            Drain: begin
                // The last-flagged beat is by construction the final word in flight.
                if (pop && fifo_rd_data[CDataLen]) begin
                    state_d = Idle;
                    done_d  = 1'b1;
                end else begin
                    state_d = Drain;
                end
            end
            default: begin
                state_d = Idle;
            end
        endcase
        if (abort) begin
            state_d         = Idle;
            remaining_d     = '0;
            inflight_d      = 1'b0;
            inflight_last_d = 1'b0;
            done_d          = 1'b1;
        end else begin
            done_d = done_d;
        end
    end

    // State registers; everything freezes while the clock enable is low.
    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
            state_q         <= Idle;
            addr_q          <= '0;
            ram_addr_q      <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else if (AClkHEn) begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            ram_addr_q      <= ram_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    assign bus.ABusy    = (state_q != Idle);
    assign bus.ADone    = done_q;
    assign bus.ARamRdEn = issue;
    // Address holds the last issued word when idle so RAM output stays meaningful.
    assign bus.ARamAddr = issue ? addr_q : ram_addr_q;
    assign bus.AStrVld  = ~fifo_empty;
    assign bus.AStrData = fifo_rd_data[CDataLen-1:0];
    assign bus.AStrLast = fifo_rd_data[CDataLen];

endmodule
